// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer owning the HI/LO registers.
// Runs beside the main pipeline. It sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO
// from the X stage, and holds X on MFHI/MFLO or new md ops while busy.
//
// Ports
//   clock, reset_n       sole clock (rising edge), async active-low reset
//   x_valid, x_flush     X-stage instr valid / being killed this cycle
//   x_opcode, x_fn       X-stage opcode and function field
//   x_op1_val, x_op2_val rs / rt operand values
//   md_busy              operation in flight (registered)
//   md_stall             hold the X-stage instr this cycle
//   md_hi, md_lo         HI / LO registers
//
// state | meaning
// IDLE  | no op in flight; HI/LO hold the last result
// MUL   | shift-add multiply, BITS_PER_CYCLE product bits per cycle
// DIV   | restoring divide, BITS_PER_CYCLE quotient bits per cycle
// FIXUP | apply result signs, write HI/LO, return to IDLE
module muldiv_ctrl #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        x_valid,
   input  logic        x_flush,
   input  logic [5:0]  x_opcode,
   input  logic [5:0]  x_fn,
   input  logic [31:0] x_op1_val,
   input  logic [31:0] x_op2_val,
   output logic        md_busy,
   output logic        md_stall,
   output logic [31:0] md_hi,
   output logic [31:0] md_lo
);

   localparam logic [5:0] OP_REG   = 6'h00;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam int         ITERS    = 32 / BITS_PER_CYCLE;
   localparam logic [4:0] CNT_LOAD = 5'(ITERS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] opb_q, opb_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        mul_q, mul_d;
   logic        neg_lo_q, neg_lo_d;
   logic        neg_hi_q, neg_hi_d;

   logic        md_op, accept, signed_op, s1, s2;
   logic [31:0] a_mag, b_mag;
   logic [63:0] step_acc;
   logic [32:0] sum, part;
   logic        qb;

   always_comb begin
      md_op = 1'b0;
      if (x_opcode == OP_REG) begin
         case (x_fn)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: md_op = 1'b1;
            default: md_op = 1'b0;
         endcase
      end
   end

   assign accept    = x_valid & ~x_flush & md_op & ~busy_q;
   assign md_stall  = x_valid & ~x_flush & md_op & busy_q;
   assign signed_op = (x_fn == FN_MULT) || (x_fn == FN_DIV);
   assign s1        = signed_op & x_op1_val[31];
   assign s2        = signed_op & x_op2_val[31];
   assign a_mag     = s1 ? -x_op1_val : x_op1_val;
   assign b_mag     = s2 ? -x_op2_val : x_op2_val;

   // acc holds {hi, lo}: for MUL lo is the multiplier shifting out while the
   // product fills from the top; for DIV lo is the dividend shifting out
   // while quotient bits shift in, and hi is the partial remainder.
   always_comb begin
      step_acc = acc_q;
      sum      = '0;
      part     = '0;
      qb       = 1'b0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (state_q == S_MUL) begin
            sum      = {1'b0, step_acc[63:32]} + (step_acc[0] ? {1'b0, opb_q} : 33'd0);
            step_acc = {sum, step_acc[31:1]};
         end else begin
            part = {step_acc[63:32], step_acc[31]};
            qb   = (part >= {1'b0, opb_q});
            if (qb) part = part - {1'b0, opb_q};
            step_acc = {part[31:0], step_acc[30:0], qb};
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mul_d    = mul_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (x_fn)
                  FN_MTHI: hi_d = x_op1_val;
                  FN_MTLO: lo_d = x_op1_val;
                  FN_MULT, FN_MULTU: begin
                     state_d  = S_MUL;
                     cnt_d    = CNT_LOAD;
                     acc_d    = {32'd0, b_mag};
                     opb_d    = a_mag;
                     mul_d    = 1'b1;
                     neg_lo_d = s1 ^ s2;
                     neg_hi_d = s1 ^ s2;
                  end
                  FN_DIV, FN_DIVU: begin
                     state_d  = S_DIV;
                     cnt_d    = CNT_LOAD;
                     acc_d    = {32'd0, a_mag};
                     opb_d    = b_mag;
                     mul_d    = 1'b0;
                     // Divide by zero leaves quotient all-ones and remainder
                     // = |op1|; re-applying s1 to the remainder restores the
                     // raw op1, so only the quotient negation is suppressed.
                     neg_lo_d = (s1 ^ s2) & (x_op2_val != 32'd0);
                     neg_hi_d = s1;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            acc_d = step_acc;
            if (cnt_q == 5'd0) state_d = S_FIXUP;
            else               cnt_d   = cnt_q - 5'd1;
         end
         S_FIXUP: begin
            if (mul_q) begin
               {hi_d, lo_d} = neg_lo_q ? (64'd0 - acc_q) : acc_q;
            end else begin
               hi_d = neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
               lo_d = neg_lo_q ? -acc_q[31:0]  : acc_q[31:0];
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         mul_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         mul_q    <= mul_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
      end
   end

   assign md_busy = busy_q;
   assign md_hi   = hi_q;
   assign md_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        x_valid, x_flush;
   logic [5:0]  x_opcode, x_fn;
   logic [31:0] x_op1_val, x_op2_val;
   logic        md_busy, md_stall;
   logic [31:0] md_hi, md_lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   muldiv_ctrl #(.BITS_PER_CYCLE(1)) dut (
      .clock(clock), .reset_n(reset_n), .x_valid(x_valid), .x_flush(x_flush),
      .x_opcode(x_opcode), .x_fn(x_fn), .x_op1_val(x_op1_val), .x_op2_val(x_op2_val),
      .md_busy(md_busy), .md_stall(md_stall), .md_hi(md_hi), .md_lo(md_lo)
   );

   always #5 clock = ~clock;

   // Architectural result of one md op, from plain integer arithmetic.
   function automatic logic [63:0] ref_md(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 0; r = 0;
      case (fn)
         F_MULT:  res = 64'(sa * sb);
         F_MULTU: res = {32'd0, a} * {32'd0, b};
         F_DIV: begin
            if (b == 32'd0) res = {a, 32'hFFFFFFFF};
            else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
         end
         F_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
         F_MTHI:  res = {a, lo};
         F_MTLO:  res = {hi, a};
         default: res = {hi, lo};
      endcase
      return res;
   endfunction

   task automatic drive(input logic v, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic fl);
      x_valid = v; x_opcode = 6'h00; x_fn = fn; x_op1_val = a; x_op2_val = b; x_flush = fl;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (md_busy && cyc < 100) begin
         cyc++;
         @(negedge clock);
      end
   endtask

   task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, output int cyc);
      @(negedge clock);
      drive(1'b1, fn, a, b, fl);
      @(negedge clock);
      drive(1'b0, F_MFHI, 32'd0, 32'd0, 1'b0);
      wait_idle(cyc);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      drive(1'b1, F_MULT, 32'd3, 32'd4, 1'b0);
      repeat (3) @(negedge clock);
      checks++;
      if (md_busy !== 1'b0 || md_hi !== 32'd0 || md_lo !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b hi=%h lo=%h, required 0/0/0", md_busy, md_hi, md_lo);
      end
      checks++;
      if (md_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall: stall=%b, required 0", md_stall);
      end
      drive(1'b0, F_MFHI, 32'd0, 32'd0, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic check_op(input string name, input logic [5:0] fn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
      int cyc;
      run_op(fn, a, b, 1'b0, cyc);
      checks++;
      if (cyc != 33) begin
         errors++;
         $display("FAIL %s_busy: busy cycles=%0d, required 33", name, cyc);
      end
      checks++;
      if (md_hi !== exp_hi || md_lo !== exp_lo) begin
         errors++;
         $display("FAIL %s_result: hi=%h lo=%h, required hi=%h lo=%h", name, md_hi, md_lo, exp_hi, exp_lo);
      end
      m_hi = exp_hi; m_lo = exp_lo;
   endtask

   task automatic test_vectors;
      check_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      check_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      check_op("multu_neg", F_MULTU, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
      check_op("div_neg",   F_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      check_op("divu_zero", F_DIVU,  32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
      check_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      check_op("div_zero",  F_DIV,   32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
   endtask

   task automatic test_mthi_flush;
      int cyc;
      logic [31:0] old_hi;
      old_hi = m_hi;
      run_op(F_MTHI, 32'h1234, 32'd0, 1'b1, cyc);
      checks++;
      if (md_hi !== old_hi || cyc != 0) begin
         errors++;
         $display("FAIL mthi_flushed: hi=%h busy=%0d, required hi=%h busy=0", md_hi, cyc, old_hi);
      end
      run_op(F_MTHI, 32'h1234, 32'd0, 1'b0, cyc);
      checks++;
      if (md_hi !== 32'h00001234 || md_lo !== m_lo || cyc != 0) begin
         errors++;
         $display("FAIL mthi: hi=%h lo=%h busy=%0d, required hi=00001234 lo=%h busy=0", md_hi, md_lo, cyc, m_lo);
      end
      m_hi = 32'h00001234;
   endtask

   // Second op held valid in X right behind a MULT; counts stalled cycles.
   task automatic stall_behind_mult(input logic [5:0] fn2, input logic [31:0] a2,
                                    input logic [31:0] b2, output int stalls);
      @(negedge clock);
      drive(1'b1, F_MULT, 32'h00012345, 32'hFFFFFF00, 1'b0);
      @(negedge clock);
      drive(1'b1, fn2, a2, b2, 1'b0);
      stalls = 0;
      while (md_stall && stalls < 100) begin
         stalls++;
         @(negedge clock);
      end
   endtask

   task automatic test_stall_mflo;
      int stalls;
      logic [63:0] p;
      p = ref_md(F_MULT, 32'h00012345, 32'hFFFFFF00, m_hi, m_lo);
      stall_behind_mult(F_MFLO, 32'd0, 32'd0, stalls);
      checks++;
      if (stalls != 33) begin
         errors++;
         $display("FAIL mflo_stall: stall cycles=%0d, required 33", stalls);
      end
      checks++;
      if (md_lo !== p[31:0] || md_hi !== p[63:32]) begin
         errors++;
         $display("FAIL mflo_result: hi=%h lo=%h, required hi=%h lo=%h", md_hi, md_lo, p[63:32], p[31:0]);
      end
      @(negedge clock);
      drive(1'b0, F_MFHI, 32'd0, 32'd0, 1'b0);
      checks++;
      if (md_busy !== 1'b0 || md_lo !== p[31:0]) begin
         errors++;
         $display("FAIL mflo_no_effect: busy=%b lo=%h, required 0 lo=%h", md_busy, md_lo, p[31:0]);
      end
      m_hi = p[63:32]; m_lo = p[31:0];
   endtask

   task automatic test_back_to_back;
      int stalls, cyc;
      logic [63:0] r;
      stall_behind_mult(F_DIV, 32'hFFFF0001, 32'd7, stalls);
      checks++;
      if (stalls != 33) begin
         errors++;
         $display("FAIL b2b_stall: stall cycles=%0d, required 33", stalls);
      end
      @(negedge clock);
      drive(1'b0, F_MFHI, 32'd0, 32'd0, 1'b0);
      wait_idle(cyc);
      r = ref_md(F_DIV, 32'hFFFF0001, 32'd7, m_hi, m_lo);
      checks++;
      if (cyc != 33 || md_hi !== r[63:32] || md_lo !== r[31:0]) begin
         errors++;
         $display("FAIL b2b_div: busy=%0d hi=%h lo=%h, required busy=33 hi=%h lo=%h", cyc, md_hi, md_lo, r[63:32], r[31:0]);
      end
      m_hi = r[63:32]; m_lo = r[31:0];
   endtask

   task automatic test_reset_abort;
      int cyc;
      run_op(F_MTLO, 32'hA5A5A5A5, 32'd0, 1'b0, cyc);
      @(negedge clock);
      drive(1'b1, F_DIV, 32'd1000, 32'd3, 1'b0);
      @(negedge clock);
      drive(1'b0, F_MFHI, 32'd0, 32'd0, 1'b0);
      repeat (9) @(negedge clock);
      reset_n = 1'b0;
      #1;
      checks++;
      if (md_busy !== 1'b0 || md_hi !== 32'd0 || md_lo !== 32'd0) begin
         errors++;
         $display("FAIL reset_abort: busy=%b hi=%h lo=%h, required 0/0/0", md_busy, md_hi, md_lo);
      end
      @(negedge clock);
      reset_n = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      check_op("after_reset", F_MULT, 32'd2, 32'd3, 32'd0, 32'd6);
   endtask

   task automatic test_random;
      int cyc, exp_cyc;
      logic [5:0] fns [8];
      logic [5:0] fn;
      logic [31:0] a, b;
      logic fl;
      logic [63:0] r;
      fns = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO};
      for (int i = 0; i < 40; i++) begin
         fn = fns[$urandom_range(0, 7)];
         case ($urandom_range(0, 7))
            0: a = 32'd0; 1: a = 32'h80000000; 2: a = 32'hFFFFFFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: b = 32'd0; 1: b = 32'h80000000; 2: b = 32'hFFFFFFFF; 3: b = 32'd1;
            default: b = $urandom;
         endcase
         fl = ($urandom_range(0, 7) == 0);
         r = fl ? {m_hi, m_lo} : ref_md(fn, a, b, m_hi, m_lo);
         exp_cyc = (!fl && (fn == F_MULT || fn == F_MULTU || fn == F_DIV || fn == F_DIVU)) ? 33 : 0;
         run_op(fn, a, b, fl, cyc);
         checks++;
         if (cyc != exp_cyc || md_hi !== r[63:32] || md_lo !== r[31:0]) begin
            errors++;
            $display("FAIL random[%0d] fn=%h a=%h b=%h fl=%b: busy=%0d hi=%h lo=%h, required busy=%0d hi=%h lo=%h",
                     i, fn, a, b, fl, cyc, md_hi, md_lo, exp_cyc, r[63:32], r[31:0]);
         end
         m_hi = r[63:32]; m_lo = r[31:0];
      end
   endtask

   initial begin
      drive(1'b0, F_MFHI, 32'd0, 32'd0, 1'b0);
      test_reset();
      test_vectors();
      test_mthi_flush();
      test_stall_mflo();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
